// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: synchronises and measures the reference, then turns
// phase-detector lead/lag decisions into DCO add/sub pulse bursts and reports lock.
module adpll_loop_ctrl #(
  parameter int unsigned ACQ_STEP     = 4,
  parameter int unsigned LOCK_CNT     = 8,
  parameter int unsigned UNLOCK_CNT   = 3,
  parameter int unsigned MEAS_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ref_in,
  input  logic       lead,
  input  logic       lag,
  output logic       ref_rise,
  output logic [9:0] ref_period,
  output logic       add_pulse,
  output logic       sub_pulse,
  output logic       locked,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    ACQUIRE = 3'd2,
    TRACK   = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_ADD  = 2'd1,
    DIR_SUB  = 2'd2
  } dir_t;

  localparam logic [9:0] PCNT_MAX    = 10'h3FF;
  localparam logic [3:0] ACQ_LEN     = 4'(ACQ_STEP);
  localparam logic [3:0] MEAS_TARGET = 4'(MEAS_PERIODS);
  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CNT);
  localparam logic [7:0] MISS_TARGET = 8'(UNLOCK_CNT);

  state_t     st;
  logic       s1, s2, d;
  logic       rise;
  logic [9:0] pcnt;
  logic       first_done;
  logic [3:0] meas_cnt;
  dir_t       last_dir;
  logic [7:0] quiet_cnt;
  logic [7:0] miss_cnt;
  logic [3:0] burst_rem;
  dir_t       burst_dir;

  dir_t       dec_dir;
  logic       active;
  logic       ref_lost;
  logic       dec_en;
  logic       reverse;
  logic [3:0] burst_len;

  assign rise     = s2 & ~d;
  assign state    = st;
  assign active   = (st == ACQUIRE) || (st == TRACK) || (st == LOCKED);
  assign ref_lost = active && (pcnt == PCNT_MAX);
  assign dec_en   = ref_rise && active && !ref_lost;
  assign reverse  = (st == ACQUIRE) && (dec_dir != DIR_NONE) &&
                    (last_dir != DIR_NONE) && (dec_dir != last_dir);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_dir = DIR_NONE;
    if (lead && !lag)      dec_dir = DIR_ADD;
    else if (lag && !lead) dec_dir = DIR_SUB;
    burst_len = 4'd1;
    if (st == ACQUIRE && !reverse) burst_len = ACQ_LEN;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      d        <= 1'b0;
      ref_rise <= 1'b0;
    end else begin
      s1       <= ref_in;
      s2       <= s1;
      d        <= s2;
      ref_rise <= rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      pcnt       <= '0;
      ref_period <= '0;
      first_done <= 1'b0;
      meas_cnt   <= '0;
      last_dir   <= DIR_NONE;
      quiet_cnt  <= '0;
      miss_cnt   <= '0;
      burst_rem  <= '0;
      burst_dir  <= DIR_NONE;
      add_pulse  <= 1'b0;
      sub_pulse  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // Burst progression: a pulse is always followed by one idle cycle.
      if (add_pulse || sub_pulse) begin
        add_pulse <= 1'b0;
        sub_pulse <= 1'b0;
      end else if (burst_rem != '0) begin
        add_pulse <= (burst_dir == DIR_ADD);
        sub_pulse <= (burst_dir == DIR_SUB);
        burst_rem <= burst_rem - 4'd1;
      end

      if (st == IDLE || !enable) pcnt <= '0;
      else if (rise)             pcnt <= '0;
      else if (pcnt != PCNT_MAX) pcnt <= pcnt + 10'd1;

      // The first rise after (re)starting only aligns pcnt; later rises are captures.
      if (st != IDLE && enable && rise && !ref_lost) begin
        if (first_done) begin
          ref_period <= (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + 10'd1;
          if (st == MEASURE && meas_cnt != 4'hF) meas_cnt <= meas_cnt + 4'd1;
        end
        first_done <= 1'b1;
      end

      if (!enable) begin
        st        <= IDLE;
        locked    <= 1'b0;
        add_pulse <= 1'b0;
        sub_pulse <= 1'b0;
        burst_rem <= '0;
      end else if (ref_lost) begin
        st         <= MEASURE;
        locked     <= 1'b0;
        add_pulse  <= 1'b0;
        sub_pulse  <= 1'b0;
        burst_rem  <= '0;
        ref_period <= PCNT_MAX;
        first_done <= 1'b0;
        meas_cnt   <= '0;
      end else begin
        // Any decision, even a quiet one, restarts the burst from its own N+1.
        if (dec_en) begin
          add_pulse <= (dec_dir == DIR_ADD);
          sub_pulse <= (dec_dir == DIR_SUB);
          burst_dir <= dec_dir;
          burst_rem <= (dec_dir == DIR_NONE) ? 4'd0 : burst_len - 4'd1;
        end
        case (st)
          IDLE: begin
            st         <= MEASURE;
            meas_cnt   <= '0;
            first_done <= 1'b0;
          end
          MEASURE: begin
            if (meas_cnt == MEAS_TARGET) begin
              st       <= ACQUIRE;
              last_dir <= DIR_NONE;
            end
          end
          ACQUIRE: begin
            if (dec_en) begin
              if (reverse) begin
                st        <= TRACK;
                quiet_cnt <= '0;
              end else if (dec_dir != DIR_NONE) begin
                last_dir <= dec_dir;
              end
            end
          end
          TRACK: begin
            if (dec_en) begin
              if (dec_dir == DIR_NONE) begin
                quiet_cnt <= quiet_cnt + 8'd1;
                if (quiet_cnt + 8'd1 == LOCK_TARGET) begin
                  st       <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                quiet_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (dec_en) begin
              if (dec_dir == DIR_NONE) begin
                miss_cnt <= '0;
              end else if (miss_cnt + 8'd1 == MISS_TARGET) begin
                st        <= TRACK;
                locked    <= 1'b0;
                quiet_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
